// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC SPI sequencer.
// The frame width is fixed by the ADC; channel config constants live with the channel-select stage.
package adc_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_BITS_W = $clog2(ADC_DATA_W + 1);

    typedef enum logic [2:0] {IDLE, CONVST, WAIT, SHIFT, DONE} adc_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SCK generator for one ADC frame: ADC_DATA_W low-then-high periods while en is high.
// rise_pulse/fall_pulse/done flag the clk edge on which sck is about to change.
module adc_sck_gen
    import adc_pkg::*;
#(
    parameter int SCK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic done
);

    localparam int                    HALF_W      = $clog2(SCK_HALF + 1);
    localparam logic [HALF_W-1:0]     HALF_LAST   = HALF_W'(SCK_HALF - 1);
    localparam logic [ADC_BITS_W-1:0] LAST_PERIOD = ADC_BITS_W'(ADC_DATA_W - 1);

    logic [HALF_W-1:0]     half_cnt_q, half_cnt_d;
    logic [ADC_BITS_W-1:0] per_cnt_q;
    logic                  sck_q;
    logic                  toggle;

    assign toggle     = en && (half_cnt_q == HALF_LAST);
    assign rise_pulse = toggle && !sck_q;
    assign fall_pulse = toggle && sck_q;
    assign done       = fall_pulse && (per_cnt_q == LAST_PERIOD);
    assign sck        = sck_q;
    assign half_cnt_d = toggle ? '0 : half_cnt_q + 1'b1;

    // Dropping en reloads everything, so each frame starts with a full low half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_q <= '0;
            per_cnt_q  <= '0;
            sck_q      <= 1'b0;
        end else if (!en) begin
            half_cnt_q <= '0;
            per_cnt_q  <= '0;
            sck_q      <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            if (toggle)     sck_q     <= ~sck_q;
            if (fall_pulse) per_cnt_q <= per_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_sequencer.sv
// Frame sequencer for the 8-channel 12-bit SPI ADC: CONVST strobe, conversion wait, 12-bit
// full-duplex shift, then a 1-cycle result strobe tagged with the config that produced it.
module adc_spi_sequencer
    import adc_pkg::*;
#(
    parameter int DATA_W        = ADC_DATA_W,
    parameter int CONVST_CYC    = 2,
    parameter int CONV_WAIT_CYC = 80,
    parameter int SCK_HALF      = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] chansel,
    output logic              busy,
    output logic              data_valid,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_cfg,
    output logic              ADC_CONVST,
    output logic              ADC_SCK,
    output logic              ADC_SDI,
    input  logic              ADC_SDO
);

    localparam int CNT_W = $clog2(max2(CONVST_CYC, CONV_WAIT_CYC) + 1);

    adc_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] tx_sr_q, rx_sr_q;
    logic [DATA_W-1:0] cur_cfg_q, prev_cfg_q;
    logic [DATA_W-1:0] result_q, result_cfg_q;
    logic              busy_q, data_valid_q, convst_q, sdi_q;
    logic              sck_rise, sck_fall, sck_done;

    adc_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .clk        (CLOCK_50),
        .rst_n      (reset_n),
        .en         (state_q == SHIFT),
        .sck        (ADC_SCK),
        .rise_pulse (sck_rise),
        .fall_pulse (sck_fall),
        .done       (sck_done)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            cur_cfg_q    <= '0;
            prev_cfg_q   <= '0;
            result_q     <= '0;
            result_cfg_q <= '0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            convst_q     <= 1'b0;
            sdi_q        <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        tx_sr_q   <= chansel;
                        cur_cfg_q <= chansel;
                        busy_q    <= 1'b1;
                        convst_q  <= 1'b1;
                        cnt_q     <= CNT_W'(CONVST_CYC - 1);
                        state_q   <= CONVST;
                    end
                end
                CONVST: begin
                    if (cnt_q == '0) begin
                        convst_q <= 1'b0;
                        sdi_q    <= tx_sr_q[DATA_W-1];
                        cnt_q    <= CNT_W'(CONV_WAIT_CYC - 1);
                        state_q  <= WAIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= SHIFT;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                SHIFT: begin
                    if (sck_rise) rx_sr_q <= {rx_sr_q[DATA_W-2:0], ADC_SDO};
                    // The ADC applies this frame's config to the next conversion, so the
                    // result going out now belongs to the previous frame's config.
                    if (sck_done) begin
                        result_q     <= rx_sr_q;
                        result_cfg_q <= prev_cfg_q;
                        prev_cfg_q   <= cur_cfg_q;
                        data_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else if (sck_fall) begin
                        tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                        sdi_q   <= tx_sr_q[DATA_W-2];
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign data_valid = data_valid_q;
    assign result     = result_q;
    assign result_cfg = result_cfg_q;
    assign ADC_CONVST = convst_q;
    assign ADC_SDI    = sdi_q;

    a_sck_in_shift: assert property (@(posedge CLOCK_50) disable iff (!reset_n)
        ADC_SCK |-> (state_q == SHIFT));
    a_convst_in_convst: assert property (@(posedge CLOCK_50) disable iff (!reset_n)
        ADC_CONVST |-> (state_q == CONVST));
    a_valid_busy: assert property (@(posedge CLOCK_50) disable iff (!reset_n)
        data_valid |-> busy);
    a_valid_single: assert property (@(posedge CLOCK_50) disable iff (!reset_n)
        data_valid |=> !data_valid);

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Bench for adc_spi_sequencer: default build (A) and a fast build (B, SCK_HALF=1, CONV_WAIT_CYC=3)
// share stimulus; a behavioural ADC model drives SDO and captures SDI on the selected build.
module tb_adc_spi_sequencer;

    localparam int TMO = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] chansel = '0;
    logic        sdo = 1'b0;
    bit          sel = 1'b0;
    logic        start_a, start_b;

    logic        a_busy, a_dv, a_cv, a_sck, a_sdi;
    logic [11:0] a_res, a_rcfg;
    logic        b_busy, b_dv, b_cv, b_sck, b_sdi;
    logic [11:0] b_res, b_rcfg;
    logic        o_busy, o_dv, o_cv, o_sck, o_sdi;
    logic [11:0] o_res, o_rcfg;

    int checks = 0;
    int errors = 0;

    logic [11:0] m_val = '0, m_cap = '0, m_res = '0, m_rcfg = '0;
    int          m_rise = 0, m_cv = 0, m_dv = 0, m_idx = 0;
    logic        sck_prev = 1'b0, cv_prev = 1'b0, dv_prev = 1'b0;
    logic [11:0] ref_prev = '0;

    always #5 clk = ~clk;

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign o_busy  = sel ? b_busy : a_busy;
    assign o_dv    = sel ? b_dv   : a_dv;
    assign o_cv    = sel ? b_cv   : a_cv;
    assign o_sck   = sel ? b_sck  : a_sck;
    assign o_sdi   = sel ? b_sdi  : a_sdi;
    assign o_res   = sel ? b_res  : a_res;
    assign o_rcfg  = sel ? b_rcfg : a_rcfg;

    adc_spi_sequencer dut_a (
        .CLOCK_50 (clk), .reset_n (rst_n), .start (start_a), .chansel (chansel),
        .busy (a_busy), .data_valid (a_dv), .result (a_res), .result_cfg (a_rcfg),
        .ADC_CONVST (a_cv), .ADC_SCK (a_sck), .ADC_SDI (a_sdi), .ADC_SDO (sdo)
    );

    adc_spi_sequencer #(.CONV_WAIT_CYC (3), .SCK_HALF (1)) dut_b (
        .CLOCK_50 (clk), .reset_n (rst_n), .start (start_b), .chansel (chansel),
        .busy (b_busy), .data_valid (b_dv), .result (b_res), .result_cfg (b_rcfg),
        .ADC_CONVST (b_cv), .ADC_SCK (b_sck), .ADC_SDI (b_sdi), .ADC_SDO (sdo)
    );

    function automatic int frame_len(input int sck_half, input int conv_wait);
        return 1 + 2 + conv_wait + 24 * sck_half + 1;
    endfunction

    // ADC model and protocol monitor, sampled between clock edges.
    always @(posedge clk) begin
        #2;
        if (o_cv) m_cv++;
        if (o_cv && !cv_prev) begin
            m_idx = 11;
            sdo   = m_val[11];
        end
        if (o_sck && !sck_prev) begin
            m_rise++;
            m_cap = {m_cap[10:0], o_sdi};
        end
        if (!o_sck && sck_prev && m_idx > 0) begin
            m_idx--;
            sdo = m_val[m_idx];
        end
        if (o_dv) begin
            m_dv++;
            m_res  = o_res;
            m_rcfg = o_rcfg;
        end
        if ((o_sck && (o_cv || !o_busy)) || (o_cv && !o_busy) || (o_dv && (!o_busy || dv_prev))) begin
            errors++;
            $display("FAIL protocol: sck=%b convst=%b busy=%b dv=%b dv_prev=%b", o_sck, o_cv, o_busy, o_dv, dv_prev);
        end
        sck_prev = o_sck;
        cv_prev  = o_cv;
        dv_prev  = o_dv;
    end

    task automatic clr_model(input logic [11:0] val);
        m_val = val; m_cap = '0; m_rise = 0; m_cv = 0; m_dv = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_prev = '0;
        @(negedge clk);
    endtask

    // Runs one frame from an idle negedge; returns at the negedge where busy is seen low.
    task automatic do_frame(input logic [11:0] cfg, input logic [11:0] val, output int cyc);
        clr_model(val);
        chansel = cfg;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chansel = 12'($urandom);
        cyc = 1;
        while (o_busy && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_busy, a_dv, a_cv, a_sck, a_sdi, a_res, a_rcfg} !== '0) begin
            errors++;
            $display("FAIL reset_a: got busy=%b dv=%b cv=%b sck=%b sdi=%b res=%h cfg=%h, want all 0",
                     a_busy, a_dv, a_cv, a_sck, a_sdi, a_res, a_rcfg);
        end
        checks++;
        if ({b_busy, b_dv, b_cv, b_sck, b_sdi, b_res, b_rcfg} !== '0) begin
            errors++;
            $display("FAIL reset_b: got busy=%b dv=%b cv=%b sck=%b sdi=%b res=%h cfg=%h, want all 0",
                     b_busy, b_dv, b_cv, b_sck, b_sdi, b_res, b_rcfg);
        end
    endtask

    task automatic test_basic();
        int cyc;
        do_frame(12'h880, 12'hA5C, cyc);
        checks++;
        if (cyc !== frame_len(2, 80)) begin errors++; $display("FAIL basic_len: got %0d want %0d", cyc, frame_len(2, 80)); end
        checks++;
        if (m_cv !== 2) begin errors++; $display("FAIL basic_convst: got %0d cycles want 2", m_cv); end
        checks++;
        if (m_rise !== 12) begin errors++; $display("FAIL basic_rises: got %0d want 12", m_rise); end
        checks++;
        if (m_cap !== 12'h880) begin errors++; $display("FAIL basic_sdi: got %h want 880", m_cap); end
        checks++;
        if (m_dv !== 1 || m_res !== 12'hA5C || m_rcfg !== 12'h000) begin
            errors++;
            $display("FAIL basic_result: got dv=%0d res=%h cfg=%h want dv=1 res=a5c cfg=000", m_dv, m_res, m_rcfg);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (o_res !== 12'hA5C || o_sdi !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got res=%h sdi=%b want res=a5c sdi=0", o_res, o_sdi);
        end
        ref_prev = 12'h880;
    endtask

    task automatic test_back_to_back();
        logic [11:0] cfgs [2] = '{12'hC80, 12'h980};
        logic [11:0] vals [2] = '{12'h123, 12'hFFF};
        int cyc;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            do_frame(cfgs[i], vals[i], cyc);
            checks++;
            if (cyc !== frame_len(2, 80) || m_dv !== 1) begin
                errors++;
                $display("FAIL b2b_len[%0d]: got len=%0d dv=%0d want len=%0d dv=1", i, cyc, m_dv, frame_len(2, 80));
            end
            checks++;
            if (m_res !== vals[i] || m_rcfg !== ref_prev || m_cap !== cfgs[i]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got res=%h cfg=%h sdi=%h want res=%h cfg=%h sdi=%h",
                         i, m_res, m_rcfg, m_cap, vals[i], ref_prev, cfgs[i]);
            end
            ref_prev = cfgs[i];
        end
    endtask

    task automatic test_random();
        logic [11:0] cfg, val;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            cfg = 12'($urandom);
            val = 12'($urandom);
            do_frame(cfg, val, cyc);
            checks++;
            if (m_dv !== 1 || m_res !== val || m_rcfg !== ref_prev || m_cap !== cfg || o_sdi !== cfg[0]) begin
                errors++;
                $display("FAIL rand[%0d]: got dv=%0d res=%h cfg=%h sdi=%h last=%b want dv=1 res=%h cfg=%h sdi=%h last=%b",
                         i, m_dv, m_res, m_rcfg, m_cap, o_sdi, val, ref_prev, cfg, cfg[0]);
            end
            ref_prev = cfg;
        end
    endtask

    task automatic test_start_flood();
        logic [11:0] cfg, cfg2, val, val2;
        int cyc;
        cfg  = 12'($urandom); cfg2 = 12'($urandom);
        val  = 12'($urandom); val2 = 12'($urandom);
        clr_model(val);
        chansel = cfg;
        start   = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (o_busy && cyc < TMO) begin
            chansel = 12'($urandom);
            @(negedge clk);
            cyc++;
        end
        chansel = cfg2;
        checks++;
        if (cyc !== frame_len(2, 80) || m_dv !== 1 || m_cv !== 2) begin
            errors++;
            $display("FAIL flood_single: got len=%0d dv=%0d convst=%0d want len=%0d dv=1 convst=2",
                     cyc, m_dv, m_cv, frame_len(2, 80));
        end
        checks++;
        if (m_cap !== cfg || m_res !== val || m_rcfg !== ref_prev) begin
            errors++;
            $display("FAIL flood_data: got sdi=%h res=%h cfg=%h want sdi=%h res=%h cfg=%h",
                     m_cap, m_res, m_rcfg, cfg, val, ref_prev);
        end
        ref_prev = cfg;
        clr_model(val2);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL flood_reaccept: got busy=%b want 1", o_busy); end
        cyc = 0;
        while (o_busy && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (m_cap !== cfg2 || m_res !== val2 || m_rcfg !== ref_prev || m_dv !== 1) begin
            errors++;
            $display("FAIL flood_next: got sdi=%h res=%h cfg=%h dv=%0d want sdi=%h res=%h cfg=%h dv=1",
                     m_cap, m_res, m_rcfg, m_dv, cfg2, val2, ref_prev);
        end
        ref_prev = cfg2;
    endtask

    task automatic test_reset_mid();
        logic [11:0] cfg, val;
        int n, cyc;
        clr_model(12'($urandom));
        chansel = 12'hFFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (m_rise < 6 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_rise !== 6 || o_sck !== 1'b1) begin errors++; $display("FAIL midrst_reach: got rises=%0d sck=%b want 6/1", m_rise, o_sck); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_cv, o_sck, o_sdi, o_busy, o_dv} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got cv=%b sck=%b sdi=%b busy=%b dv=%b want all 0", o_cv, o_sck, o_sdi, o_busy, o_dv);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ref_prev = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (m_dv !== 0) begin errors++; $display("FAIL midrst_novalid: got %0d pulses want 0", m_dv); end
        cfg = 12'($urandom);
        val = 12'($urandom);
        do_frame(cfg, val, cyc);
        checks++;
        if (cyc !== frame_len(2, 80) || m_res !== val || m_rcfg !== 12'h000 || m_cap !== cfg) begin
            errors++;
            $display("FAIL midrst_clean: got len=%0d res=%h cfg=%h sdi=%h want len=%0d res=%h cfg=000 sdi=%h",
                     cyc, m_res, m_rcfg, m_cap, frame_len(2, 80), val, cfg);
        end
        ref_prev = cfg;
    endtask

    task automatic test_fast();
        logic [11:0] vals [2] = '{12'h001, 12'h800};
        logic [11:0] cfg;
        int cyc;
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cfg = 12'($urandom);
            do_frame(cfg, vals[i], cyc);
            checks++;
            if (cyc !== frame_len(1, 3) || m_rise !== 12 || m_cv !== 2) begin
                errors++;
                $display("FAIL fast_len[%0d]: got len=%0d rises=%0d convst=%0d want len=%0d rises=12 convst=2",
                         i, cyc, m_rise, m_cv, frame_len(1, 3));
            end
            checks++;
            if (m_res !== vals[i] || m_rcfg !== ref_prev || m_cap !== cfg || m_dv !== 1) begin
                errors++;
                $display("FAIL fast_data[%0d]: got res=%h cfg=%h sdi=%h dv=%0d want res=%h cfg=%h sdi=%h dv=1",
                         i, m_res, m_rcfg, m_cap, m_dv, vals[i], ref_prev, cfg);
            end
            ref_prev = cfg;
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_start_flood();
        test_reset_mid();
        test_fast();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
